wb_regfile: RTL and testbench
=============================

WB_REGFILE -- requirements
Module: wb_regfile

Interface
REQ-001 SHALL have a single clock and a synchronous, active-high reset: clk and rst; rst is sampled only on the rising edge of clk.
REQ-002 SHALL have port clk, input, 1 bit: rising-edge clock for every register in the block.
REQ-003 SHALL have port rst, input, 1 bit: synchronous reset, active-high.
REQ-004 SHALL have port stall_mem, input, 1 bit: memory stage stalled this cycle.
REQ-005 SHALL have port stall_wb, input, 1 bit: writeback stage stalled this cycle.
REQ-006 SHALL have port flush, input, 1 bit: exception flush; clears the writeback stage.
REQ-007 SHALL have port mem_wdata, input, 32 bits: result data from the memory stage.
REQ-008 SHALL have port mem_waddr, input, 5 bits: destination register from the memory stage.
REQ-009 SHALL have port mem_we, input, 1 bit: write enable from the memory stage.
REQ-010 SHALL have ports re1 and re2, input, 1 bit each: read enables.
REQ-011 SHALL have ports raddr1 and raddr2, input, 5 bits each: read addresses.
REQ-012 SHALL have ports rdata1 and rdata2, output, 32 bits each: read data.
REQ-013 SHALL have ports wb_wdata (32 bits), wb_waddr (5 bits) and wb_we (1 bit), output: registered writeback-stage contents, exported for forwarding and debug.

Function
REQ-014 SHALL update the writeback stage register on each rising clk edge, with priority order rst > flush > bubble > capture > hold.
REQ-015 SHALL, when rst=1 or flush=1 at the edge, load wb_wdata=0, wb_waddr=0 and wb_we=0.
REQ-016 SHALL, when stall_mem=1 and stall_wb=0, insert a bubble: wb_we=0, wb_waddr=0, wb_wdata=0.
REQ-017 SHALL, when stall_mem=0, capture mem_wdata, mem_waddr and mem_we; latency from the memory-stage inputs to the wb_* outputs is exactly 1 cycle.
REQ-018 SHALL, when stall_mem=1 and stall_wb=1, hold all wb_* values unchanged.
REQ-019 SHALL, on a rising edge with rst=0 and wb_we=1 and wb_waddr!=0, write wb_wdata into register wb_waddr.
REQ-020 SHALL never alter register 0; a write to address 0 is silently dropped.
REQ-021 SHALL compute each read port combinationally, first matching rule wins:
  - rst=1 gives 0.
  - re=0 gives 0.
  - raddr=0 gives 0.
  - raddr==wb_waddr and wb_we=1 gives wb_wdata (same-cycle write-to-read bypass).
  - otherwise, the stored register value.
REQ-022 SHALL apply the bypass independently to both read ports, including when raddr1==raddr2.
REQ-023 SHALL allow a write and two reads in the same cycle with no structural stall.

Reset
REQ-024 SHALL clear the wb_* outputs to 0 on a rising edge with rst=1.
REQ-025 SHALL clear registers 1..31 to 0 on a rising edge with rst=1.
REQ-026 SHALL drive rdata1 and rdata2 to 0 while rst=1.
REQ-027 SHALL, when rst is asserted mid-stream, give reset precedence over flush, stall and capture, and discard any pending write.

Structure
REQ-028 SHALL keep the following shared constants in the common definitions file: register-bus width, register-address width, register count, zero word, NOP register address, and the write enable/disable and reset enable levels.
REQ-029 SHALL place the stage register of REQ-014 to REQ-018 in one sub-module, mem_wb; the register array and read logic live in the top level.

Verification
REQ-030 SHALL show capture and write-back:
  - Stimulus: mem_we=1, mem_waddr=5, mem_wdata=0xDEADBEEF, no stalls.
  - Response: the wb_* outputs show those values after 1 edge; raddr1=5, re1=1 reads 0xDEADBEEF.
REQ-031 SHALL show the bypass:
  - Stimulus: wb_we=1, wb_waddr=7, wb_wdata=0x12345678, with raddr2=7, re2=1 in the same cycle.
  - Response: rdata2=0x12345678 before the write edge.
REQ-032 SHALL show register 0 protection:
  - Stimulus: write 0xFFFFFFFF to address 0.
  - Response: reading raddr1=0 returns 0 both before and after the edge.
REQ-033 SHALL show stall behaviour:
  - Stimulus: stall_mem=1 with stall_wb=0 for 1 cycle.
  - Response: wb_we=0 (bubble).
  - Stimulus: stall_mem=1 with stall_wb=1.
  - Response: the previous wb_* values are held for the whole stall.
REQ-034 SHALL show flush precedence:
  - Stimulus: flush=1 with mem_we=1, mem_waddr=3.
  - Response: wb_we=0, and register 3 is unchanged on the next edge.
REQ-035 SHALL show reset mid-operation:
  - Stimulus: registers 1..31 loaded with nonzero data, then rst=1 for 1 edge.
  - Response: all reads return 0, and wb_we=0.

Source files
------------

// File: rtl/wb_regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile_pkg
// Description : Shared widths, levels and the writeback-stage record for the
//               register file and its mem/wb stage register.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_regfile_pkg;

    localparam int REG_BUS_W  = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_NUM    = 32;

    localparam logic [REG_BUS_W-1:0]  ZERO_WORD    = '0;
    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;

    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;
    localparam logic RST_ENABLE    = 1'b1;

    typedef struct packed {
        logic                  we;
        logic [REG_ADDR_W-1:0] waddr;
        logic [REG_BUS_W-1:0]  wdata;
    } wb_stage_t;

    localparam wb_stage_t WB_NOP = '{we: WRITE_DISABLE, waddr: NOP_REG_ADDR, wdata: ZERO_WORD};

    // First matching rule wins; the bypass lets a read see this cycle's write.
    function automatic logic [REG_BUS_W-1:0] read_port(
        input logic                  rst_lvl,
        input logic                  re,
        input logic [REG_ADDR_W-1:0] raddr,
        input wb_stage_t             wb,
        input logic [REG_BUS_W-1:0]  stored
    );
        if (rst_lvl == RST_ENABLE)                             return ZERO_WORD;
        else if (re != WRITE_ENABLE)                           return ZERO_WORD;
        else if (raddr == NOP_REG_ADDR)                        return ZERO_WORD;
        else if (raddr == wb.waddr && wb.we == WRITE_ENABLE)   return wb.wdata;
        else                                                   return stored;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_regfile_mem_wb.sv
`default_nettype none
// ============================================================================
// Module      : mem_wb
// Description : Memory-to-writeback stage register with flush, bubble and hold.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_wb
    import wb_regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_mem,
    input  logic                  stall_wb,
    input  logic                  flush,
    input  logic [REG_BUS_W-1:0]  mem_wdata,
    input  logic [REG_ADDR_W-1:0] mem_waddr,
    input  logic                  mem_we,
    output logic [REG_BUS_W-1:0]  wb_wdata,
    output logic [REG_ADDR_W-1:0] wb_waddr,
    output logic                  wb_we
);

    wb_stage_t stage_q;
    wb_stage_t stage_d;

    // Stalled memory stage with a free writeback stage drains as a bubble.
    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            stage_d = WB_NOP;
        end else if (stall_mem && !stall_wb) begin
            stage_d = WB_NOP;
        end else if (!stall_mem) begin
            stage_d = '{we: mem_we, waddr: mem_waddr, wdata: mem_wdata};
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            stage_q <= WB_NOP;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign wb_wdata = stage_q.wdata;
    assign wb_waddr = stage_q.waddr;
    assign wb_we    = stage_q.we;

endmodule
`default_nettype wire

// File: rtl/wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : wb_regfile
// Description : 32x32 register file with two bypassed read ports, fed by a
//               mem/wb stage register.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_regfile
    import wb_regfile_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall_mem,
    input  logic                  stall_wb,
    input  logic                  flush,
    input  logic [REG_BUS_W-1:0]  mem_wdata,
    input  logic [REG_ADDR_W-1:0] mem_waddr,
    input  logic                  mem_we,
    input  logic                  re1,
    input  logic                  re2,
    input  logic [REG_ADDR_W-1:0] raddr1,
    input  logic [REG_ADDR_W-1:0] raddr2,
    output logic [REG_BUS_W-1:0]  rdata1,
    output logic [REG_BUS_W-1:0]  rdata2,
    output logic [REG_BUS_W-1:0]  wb_wdata,
    output logic [REG_ADDR_W-1:0] wb_waddr,
    output logic                  wb_we
);

    logic [REG_BUS_W-1:0] regs_q [REG_NUM];
    wb_stage_t            wb_stage;

    mem_wb u_mem_wb (
        .clk       (clk),
        .rst       (rst),
        .stall_mem (stall_mem),
        .stall_wb  (stall_wb),
        .flush     (flush),
        .mem_wdata (mem_wdata),
        .mem_waddr (mem_waddr),
        .mem_we    (mem_we),
        .wb_wdata  (wb_wdata),
        .wb_waddr  (wb_waddr),
        .wb_we     (wb_we)
    );

    assign wb_stage = '{we: wb_we, waddr: wb_waddr, wdata: wb_wdata};

    // Entry 0 is cleared on reset and never written afterwards.
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            for (int i = 0; i < REG_NUM; i++) begin
                regs_q[i] <= ZERO_WORD;
            end
        end else if (wb_we == WRITE_ENABLE && wb_waddr != NOP_REG_ADDR) begin
            regs_q[wb_waddr] <= wb_wdata;
        end
    end

    assign rdata1 = read_port(rst, re1, raddr1, wb_stage, regs_q[raddr1]);
    assign rdata2 = read_port(rst, re2, raddr2, wb_stage, regs_q[raddr2]);

endmodule
`default_nettype wire

// File: tb/tb_wb_regfile.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_regfile
// Description : Directed self-checking bench for wb_regfile.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_mem, stall_wb, flush;
    logic [31:0] mem_wdata;
    logic [4:0]  mem_waddr;
    logic        mem_we;
    logic        re1, re2;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2;
    logic [31:0] wb_wdata;
    logic [4:0]  wb_waddr;
    logic        wb_we;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_regfile dut (
        .clk       (clk),
        .rst       (rst),
        .stall_mem (stall_mem),
        .stall_wb  (stall_wb),
        .flush     (flush),
        .mem_wdata (mem_wdata),
        .mem_waddr (mem_waddr),
        .mem_we    (mem_we),
        .re1       (re1),
        .re2       (re2),
        .raddr1    (raddr1),
        .raddr2    (raddr2),
        .rdata1    (rdata1),
        .rdata2    (rdata2),
        .wb_wdata  (wb_wdata),
        .wb_waddr  (wb_waddr),
        .wb_we     (wb_we)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic mem_drive(input logic we, input logic [4:0] a, input logic [31:0] d);
        mem_we    = we;
        mem_waddr = a;
        mem_wdata = d;
    endtask

    task automatic test_reset();
        rst = 1'b1; re1 = 1'b1; raddr1 = 5'd5; re2 = 1'b1; raddr2 = 5'd9;
        mem_drive(1'b1, 5'd5, 32'h1111_1111);
        tick(); tick();
        settle();
        total++; if (wb_we !== 1'b0) begin bad++; $display("FAIL reset_wb_we got=%b exp=0", wb_we); end
        total++; if (wb_waddr !== 5'd0) begin bad++; $display("FAIL reset_wb_waddr got=%0d exp=0", wb_waddr); end
        total++; if (wb_wdata !== 32'h0) begin bad++; $display("FAIL reset_wb_wdata got=%h exp=0", wb_wdata); end
        total++; if (rdata1 !== 32'h0) begin bad++; $display("FAIL reset_rdata1 got=%h exp=0", rdata1); end
        total++; if (rdata2 !== 32'h0) begin bad++; $display("FAIL reset_rdata2 got=%h exp=0", rdata2); end
        rst = 1'b0;
        mem_drive(1'b0, 5'd0, 32'h0);
        tick();
    endtask

    task automatic test_capture();
        mem_drive(1'b1, 5'd5, 32'hDEAD_BEEF);
        re1 = 1'b1; raddr1 = 5'd5;
        tick();
        mem_drive(1'b0, 5'd0, 32'h0);
        settle();
        total++; if (wb_we !== 1'b1) begin bad++; $display("FAIL cap_wb_we got=%b exp=1", wb_we); end
        total++; if (wb_waddr !== 5'd5) begin bad++; $display("FAIL cap_wb_waddr got=%0d exp=5", wb_waddr); end
        total++; if (wb_wdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL cap_wb_wdata got=%h exp=deadbeef", wb_wdata); end
        total++; if (rdata1 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL cap_bypass_rd1 got=%h exp=deadbeef", rdata1); end
        tick();
        total++; if (wb_we !== 1'b0) begin bad++; $display("FAIL cap_next_wb_we got=%b exp=0", wb_we); end
        total++; if (rdata1 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL cap_stored_rd1 got=%h exp=deadbeef", rdata1); end
        re1 = 1'b0; settle();
        total++; if (rdata1 !== 32'h0) begin bad++; $display("FAIL cap_re1_off got=%h exp=0", rdata1); end
    endtask

    task automatic test_bypass();
        mem_drive(1'b1, 5'd7, 32'h1234_5678);
        tick();
        mem_drive(1'b0, 5'd0, 32'h0);
        re1 = 1'b1; raddr1 = 5'd7; re2 = 1'b1; raddr2 = 5'd7;
        settle();
        total++; if (rdata2 !== 32'h1234_5678) begin bad++; $display("FAIL byp_rd2 got=%h exp=12345678", rdata2); end
        total++; if (rdata1 !== 32'h1234_5678) begin bad++; $display("FAIL byp_rd1_same_addr got=%h exp=12345678", rdata1); end
        raddr1 = 5'd5; settle();
        total++; if (rdata1 !== 32'hDEAD_BEEF) begin bad++; $display("FAIL byp_rd1_other got=%h exp=deadbeef", rdata1); end
        re2 = 1'b0; settle();
        total++; if (rdata2 !== 32'h0) begin bad++; $display("FAIL byp_re2_off got=%h exp=0", rdata2); end
        re2 = 1'b1;
        tick();
        total++; if (rdata2 !== 32'h1234_5678) begin bad++; $display("FAIL byp_stored_rd2 got=%h exp=12345678", rdata2); end
    endtask

    task automatic test_reg0();
        mem_drive(1'b1, 5'd0, 32'hFFFF_FFFF);
        tick();
        mem_drive(1'b0, 5'd0, 32'h0);
        re1 = 1'b1; raddr1 = 5'd0;
        settle();
        total++; if (wb_we !== 1'b1) begin bad++; $display("FAIL r0_wb_we got=%b exp=1", wb_we); end
        total++; if (rdata1 !== 32'h0) begin bad++; $display("FAIL r0_before got=%h exp=0", rdata1); end
        tick();
        total++; if (rdata1 !== 32'h0) begin bad++; $display("FAIL r0_after got=%h exp=0", rdata1); end
    endtask

    task automatic test_stall();
        mem_drive(1'b1, 5'd9, 32'hAAAA_5555);
        tick();
        stall_mem = 1'b1; stall_wb = 1'b0;
        mem_drive(1'b1, 5'd10, 32'h0000_0001);
        tick();
        total++; if (wb_we !== 1'b0) begin bad++; $display("FAIL bubble_wb_we got=%b exp=0", wb_we); end
        total++; if (wb_waddr !== 5'd0) begin bad++; $display("FAIL bubble_wb_waddr got=%0d exp=0", wb_waddr); end
        total++; if (wb_wdata !== 32'h0) begin bad++; $display("FAIL bubble_wb_wdata got=%h exp=0", wb_wdata); end
        stall_mem = 1'b0;
        mem_drive(1'b1, 5'd11, 32'h0BAD_F00D);
        tick();
        stall_mem = 1'b1; stall_wb = 1'b1;
        mem_drive(1'b1, 5'd12, 32'h7777_7777);
        for (int c = 0; c < 3; c++) begin
            tick();
            total++;
            if (wb_we !== 1'b1 || wb_waddr !== 5'd11 || wb_wdata !== 32'h0BAD_F00D) begin
                bad++;
                $display("FAIL hold_cycle%0d got=%b/%0d/%h exp=1/11/0badf00d", c, wb_we, wb_waddr, wb_wdata);
            end
        end
        stall_mem = 1'b0; stall_wb = 1'b0;
        mem_drive(1'b0, 5'd0, 32'h0);
        tick();
        re1 = 1'b1; re2 = 1'b1; raddr1 = 5'd9; raddr2 = 5'd12; settle();
        total++; if (rdata1 !== 32'hAAAA_5555) begin bad++; $display("FAIL stall_reg9 got=%h exp=aaaa5555", rdata1); end
        total++; if (rdata2 !== 32'h0) begin bad++; $display("FAIL stall_reg12 got=%h exp=0", rdata2); end
        raddr1 = 5'd10; raddr2 = 5'd11; settle();
        total++; if (rdata1 !== 32'h0) begin bad++; $display("FAIL stall_reg10 got=%h exp=0", rdata1); end
        total++; if (rdata2 !== 32'h0BAD_F00D) begin bad++; $display("FAIL stall_reg11 got=%h exp=0badf00d", rdata2); end
    endtask

    task automatic test_flush();
        mem_drive(1'b1, 5'd3, 32'h3333_3333);
        tick();
        mem_drive(1'b0, 5'd0, 32'h0);
        tick();
        flush = 1'b1;
        mem_drive(1'b1, 5'd3, 32'hCAFE_BABE);
        tick();
        total++; if (wb_we !== 1'b0) begin bad++; $display("FAIL flush_wb_we got=%b exp=0", wb_we); end
        total++; if (wb_waddr !== 5'd0) begin bad++; $display("FAIL flush_wb_waddr got=%0d exp=0", wb_waddr); end
        flush = 1'b0;
        mem_drive(1'b0, 5'd0, 32'h0);
        tick();
        re1 = 1'b1; raddr1 = 5'd3; settle();
        total++; if (rdata1 !== 32'h3333_3333) begin bad++; $display("FAIL flush_reg3 got=%h exp=33333333", rdata1); end
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i < 32; i++) begin
            mem_drive(1'b1, i[4:0], 32'h1000_0000 + i);
            tick();
        end
        mem_drive(1'b1, 5'd4, 32'hDDDD_DDDD);
        tick();
        re1 = 1'b1; re2 = 1'b1; raddr1 = 5'd31; raddr2 = 5'd1; settle();
        total++; if (rdata1 !== 32'h1000_001F) begin bad++; $display("FAIL load_reg31 got=%h exp=1000001f", rdata1); end
        total++; if (rdata2 !== 32'h1000_0001) begin bad++; $display("FAIL load_reg1 got=%h exp=10000001", rdata2); end
        rst = 1'b1; settle();
        total++; if (rdata1 !== 32'h0) begin bad++; $display("FAIL rstmid_rd1_during got=%h exp=0", rdata1); end
        tick();
        rst = 1'b0;
        mem_drive(1'b0, 5'd0, 32'h0);
        settle();
        total++; if (wb_we !== 1'b0) begin bad++; $display("FAIL rstmid_wb_we got=%b exp=0", wb_we); end
        for (int i = 1; i < 32; i++) begin
            raddr1 = i[4:0]; raddr2 = 5'(32 - i); settle();
            total++;
            if (rdata1 !== 32'h0 || rdata2 !== 32'h0) begin
                bad++;
                $display("FAIL rstmid_read%0d got=%h/%h exp=0/0", i, rdata1, rdata2);
            end
        end
    endtask

    initial begin
        stall_mem = 1'b0; stall_wb = 1'b0; flush = 1'b0;
        re1 = 1'b0; re2 = 1'b0; raddr1 = 5'd0; raddr2 = 5'd0;
        mem_drive(1'b0, 5'd0, 32'h0);
        rst = 1'b1;
        test_reset();
        test_capture();
        test_bypass();
        test_reg0();
        test_stall();
        test_flush();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
